// File: rtl/occ_kl_update_if.sv
// Handshake and data bus between the Occ(k-1) fetch stage, this stage, rom_Occ and the next stage.
interface occ_kl_update_if;
    localparam int unsigned POS_W  = 5;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned PAR_W  = 8;
    localparam int unsigned ROM_W  = 32;

    // upstream parameter set
    logic              in_valid;
    logic              in_ready;
    logic [POS_W-1:0]  position;
    logic [ADDR_W-1:0] addr;
    logic [PAR_W-1:0]  i_in;
    logic [PAR_W-1:0]  z_in;
    logic [PAR_W-1:0]  k_in;
    logic [PAR_W-1:0]  l_in;
    logic [PAR_W-1:0]  data_1;

    // rom_Occ port
    logic              ce_rom_Occ;
    logic [PAR_W-1:0]  addr_rom_Occ;
    logic [ROM_W-1:0]  data;

    // downstream parameter set
    logic              out_valid;
    logic              out_ready;
    logic [POS_W-1:0]  position_out;
    logic [ADDR_W-1:0] addr_out;
    logic [PAR_W-1:0]  i_out;
    logic [PAR_W-1:0]  z_out;
    logic [PAR_W-1:0]  k_out;
    logic [PAR_W-1:0]  l_out;
    logic              empty_out;

    modport slave (
        input  in_valid, position, addr, i_in, z_in, k_in, l_in, data_1,
        input  data, out_ready,
        output in_ready, ce_rom_Occ, addr_rom_Occ,
        output out_valid, position_out, addr_out, i_out, z_out, k_out, l_out, empty_out
    );

    modport master (
        output in_valid, position, addr, i_in, z_in, k_in, l_in, data_1,
        output data, out_ready,
        input  in_ready, ce_rom_Occ, addr_rom_Occ,
        input  out_valid, position_out, addr_out, i_out, z_out, k_out, l_out, empty_out
    );
endinterface

// File: rtl/occ_kl_update.sv
// Backward-extension SA interval update: k' = C(b)+Occ(b,k-1)+1, l' = C(b)+Occ(b,l).
module occ_kl_update #(
    parameter logic [7:0] C_A = 8'd1,
    parameter logic [7:0] C_C = 8'd5,
    parameter logic [7:0] C_G = 8'd9,
    parameter logic [7:0] C_T = 8'd13
) (
    input logic             clk,
    input logic             rst,
    occ_kl_update_if.slave  bus
);
    localparam int unsigned POS_W = 5;
    localparam int unsigned PAR_W = 8;
    localparam int unsigned SUM_W = PAR_W + 1;

    // position codes; insertions then deletions, each in A,C,G,T order
    localparam logic [POS_W-1:0] POS_A_INS = 5'd9;
    localparam logic [POS_W-1:0] POS_T_DEL = 5'd16;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, CALC, DONE} state_t;

    state_t           state;
    logic [1:0]       base_q;
    logic [PAR_W-1:0] d1_q;
    logic [PAR_W-1:0] occ_l_q;

    logic             is_indel_c;
    logic [1:0]       base_in_c;
    logic [PAR_W-1:0] c_b_c;
    logic [PAR_W-1:0] occ_byte_c;
    logic [PAR_W-1:0] occ_k_c;
    logic [SUM_W-1:0] k9_c;
    logic [SUM_W-1:0] l9_c;

    // decode incoming position into indel flag and base index
    always_comb begin
        is_indel_c = 1'b0;
        base_in_c  = 2'd0;
        if (bus.position >= POS_A_INS && bus.position <= POS_T_DEL) begin
            is_indel_c = 1'b1;
            base_in_c  = 2'(bus.position - POS_A_INS);
        end
    end

    // C(b) lookup, Occ byte select and 9-bit interval sums
    always_comb begin
        case (base_q)
            2'd0:    c_b_c = C_A;
            2'd1:    c_b_c = C_C;
            2'd2:    c_b_c = C_G;
            default: c_b_c = C_T;
        endcase
        case (base_q)
            2'd0:    occ_byte_c = bus.data[7:0];
            2'd1:    occ_byte_c = bus.data[15:8];
            2'd2:    occ_byte_c = bus.data[23:16];
            default: occ_byte_c = bus.data[31:24];
        endcase
        // k==0 means k-1 wrapped, so Occ(b,k-1) is taken as zero
        occ_k_c = (bus.k_out == '0) ? '0 : d1_q;
        k9_c    = SUM_W'(c_b_c) + SUM_W'(occ_k_c) + SUM_W'(1);
        l9_c    = SUM_W'(c_b_c) + SUM_W'(occ_l_q);
    end

    // control FSM with registered outputs; parameter set latched straight into output regs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            base_q           <= '0;
            d1_q             <= '0;
            occ_l_q          <= '0;
            bus.in_ready     <= 1'b0;
            bus.ce_rom_Occ   <= 1'b0;
            bus.addr_rom_Occ <= '0;
            bus.out_valid    <= 1'b0;
            bus.position_out <= '0;
            bus.addr_out     <= '0;
            bus.i_out        <= '0;
            bus.z_out        <= '0;
            bus.k_out        <= '0;
            bus.l_out        <= '0;
            bus.empty_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        bus.in_ready     <= 1'b0;
                        bus.position_out <= bus.position;
                        bus.addr_out     <= bus.addr;
                        bus.i_out        <= bus.i_in;
                        bus.z_out        <= bus.z_in;
                        bus.k_out        <= bus.k_in;
                        bus.l_out        <= bus.l_in;
                        bus.empty_out    <= 1'b0;
                        d1_q             <= bus.data_1;
                        base_q           <= base_in_c;
                        if (is_indel_c) begin
                            bus.ce_rom_Occ   <= 1'b1;
                            bus.addr_rom_Occ <= bus.l_in;
                            state            <= FETCH;
                        end else begin
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                FETCH: begin
                    bus.ce_rom_Occ <= 1'b0;
                    state          <= CAPTURE;
                end
                CAPTURE: begin
                    occ_l_q <= occ_byte_c;
                    state   <= CALC;
                end
                CALC: begin
                    bus.k_out     <= k9_c[PAR_W-1:0];
                    bus.l_out     <= l9_c[PAR_W-1:0];
                    bus.empty_out <= k9_c[PAR_W] | l9_c[PAR_W] | (k9_c > l9_c);
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_occ_kl_update.sv
// Scoreboard bench for occ_kl_update with a registered rom_Occ model.
module tb_occ_kl_update;
    // position codes: 0 NONE, 1-4 MATCH, 5-8 SNP, 9-12 INSERTION, 13-16 DELETION, 17/18 STOP
    localparam logic [4:0] A_INS = 5'd9;
    localparam logic [4:0] C_INS = 5'd10;
    localparam logic [4:0] T_INS = 5'd12;
    localparam logic [4:0] A_DEL = 5'd13;
    localparam logic [4:0] G_MAT = 5'd3;
    localparam logic [4:0] NONE  = 5'd0;

    typedef struct {
        logic [4:0]  pos;
        logic [11:0] addr;
        logic [7:0]  i, z, k, l;
        logic        empty;
        int          lat;
        int          acc;
        int          nce;
        logic [7:0]  lrom;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    occ_kl_update_if bus0();
    occ_kl_update_if bus1();

    occ_kl_update dut0 (.clk(clk), .rst(rst), .bus(bus0));
    occ_kl_update #(.C_T(8'd250)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sb0[$];
    logic [31:0] rom0 [256];
    logic [31:0] rom1 [256];
    bit rand_rdy = 0;
    bit force_rdy = 1;
    bit ign_ce = 0;
    bit seen = 0;
    int ce_cnt = 0;
    int hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // registered ROMs: data valid the cycle after ce
    always @(posedge clk) if (bus0.ce_rom_Occ) bus0.data <= rom0[bus0.addr_rom_Occ];
    always @(posedge clk) if (bus1.ce_rom_Occ) bus1.data <= rom1[bus1.addr_rom_Occ];

    // downstream ready: random or forced
    always @(posedge clk) begin
        #1;
        bus0.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference: interval update from C table, Occ words and position class
    function automatic exp_t model(input logic [4:0] pos, input logic [11:0] addr,
                                   input logic [7:0] i, input logic [7:0] z,
                                   input logic [7:0] k, input logic [7:0] l,
                                   input logic [7:0] d1, input logic [31:0] word,
                                   input int ca, input int cc, input int cg, input int ct);
        exp_t e;
        int c [4];
        int b, occ_l, kk, ll;
        c[0] = ca; c[1] = cc; c[2] = cg; c[3] = ct;
        e.pos = pos; e.addr = addr; e.i = i; e.z = z; e.k = k; e.l = l;
        e.empty = 1'b0; e.lat = 1; e.nce = 0; e.lrom = l; e.acc = 0;
        if (int'(pos) >= 9 && int'(pos) <= 16) begin
            b = (int'(pos) - 9) % 4;
            occ_l = int'((word >> (8 * b)) & 32'hFF);
            kk = c[b] + ((k == 0) ? 0 : int'(d1)) + 1;
            ll = c[b] + occ_l;
            e.k = 8'(kk % 256);
            e.l = 8'(ll % 256);
            e.empty = (kk > 255) || (ll > 255) || (kk > ll);
            e.lat = 4;
            e.nce = 1;
        end
        return e;
    endfunction

    task automatic send0(input logic [4:0] pos, input logic [11:0] addr,
                         input logic [7:0] i, input logic [7:0] z,
                         input logic [7:0] k, input logic [7:0] l,
                         input logic [7:0] d1, input bit push, output int acc);
        exp_t e;
        int n = 0;
        acc = -1;
        @(posedge clk);
        #1;
        bus0.position = pos; bus0.addr = addr; bus0.i_in = i; bus0.z_in = z;
        bus0.k_in = k; bus0.l_in = l; bus0.data_1 = d1; bus0.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus0.in_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            check("accept_timeout", 0, 1);
            bus0.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus0.in_valid = 1'b0;
            acc = cyc;
            if (push) begin
                e = model(pos, addr, i, z, k, l, d1, rom0[l], 1, 5, 9, 13);
                e.acc = cyc;
                sb0.push_back(e);
            end
        end
    endtask

    task automatic drain0();
        int n = 0;
        while (sb0.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", sb0.size(), 0);
    endtask

    // monitor: ROM access and presented results against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.ce_rom_Occ && !ign_ce) begin
                if (sb0.size() == 0) check("ce_unexpected", 1, 0);
                else begin
                    ce_cnt++;
                    check("addr_rom_Occ", bus0.addr_rom_Occ, sb0[0].lrom);
                end
            end
            if (bus0.out_valid) begin
                if (sb0.size() == 0) check("spurious_out_valid", 1, 0);
                else begin
                    if (!seen) begin
                        check("latency", cyc - sb0[0].acc, sb0[0].lat - 1);
                        seen = 1;
                    end
                    check("position_out", bus0.position_out, sb0[0].pos);
                    check("addr_out", bus0.addr_out, sb0[0].addr);
                    check("i_out", bus0.i_out, sb0[0].i);
                    check("z_out", bus0.z_out, sb0[0].z);
                    check("k_out", bus0.k_out, sb0[0].k);
                    check("l_out", bus0.l_out, sb0[0].l);
                    check("empty_out", bus0.empty_out, sb0[0].empty);
                    check("in_ready_busy", bus0.in_ready, 0);
                    if (bus0.out_ready) begin
                        check("ce_count", ce_cnt, sb0[0].nce);
                        hs_cyc = cyc + 1;
                        void'(sb0.pop_front());
                        seen = 0;
                        ce_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n;
        exp_t e1;
        logic [7:0] kr;
        for (int a = 0; a < 256; a++) begin
            rom0[a] = $urandom;
            rom1[a] = $urandom;
        end
        rst = 1'b1;
        bus0.in_valid = 1'b1; bus0.position = C_INS; bus0.addr = 12'h123;
        bus0.i_in = 8'd1; bus0.z_in = 8'd2; bus0.k_in = 8'd3; bus0.l_in = 8'd4; bus0.data_1 = 8'd5;
        bus1.in_valid = 1'b0; bus1.position = NONE; bus1.addr = '0; bus1.i_in = '0;
        bus1.z_in = '0; bus1.k_in = '0; bus1.l_in = '0; bus1.data_1 = '0; bus1.out_ready = 1'b1;

        // reset with in_valid high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_ce", bus0.ce_rom_Occ, 0);
        check("rst_outputs", {bus0.position_out, bus0.addr_out, bus0.i_out, bus0.z_out,
                              bus0.k_out, bus0.l_out, bus0.empty_out, bus0.addr_rom_Occ}, 0);
        check("rst_in_ready", bus0.in_ready, 0);
        bus0.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", bus0.in_ready, 1);

        // directed C insertion
        rom0[6] = 32'h05040402;
        send0(C_INS, 12'h011, 8'd4, 8'd0, 8'd3, 8'd6, 8'd2, 1, acc);
        drain0();
        // A deletion with k==0: data_1 ignored
        rom0[4] = 32'hAABBCC03;
        send0(A_DEL, 12'h022, 8'd9, 8'd2, 8'd0, 8'd4, 8'hFF, 1, acc);
        drain0();
        // G match pass-through
        send0(G_MAT, 12'h0AB, 8'd7, 8'd1, 8'd10, 8'd20, 8'h33, 1, acc);
        drain0();
        // T insertion giving k'>l'
        rom0[40] = 32'h05FFFFFF;
        send0(T_INS, 12'h044, 8'd3, 8'd3, 8'd7, 8'd40, 8'd9, 1, acc);
        drain0();

        // backpressure: hold DONE, second set waits for handshake
        force_rdy = 0;
        send0(G_MAT, 12'h0CD, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 1, acc);
        fork
            send0(A_INS, 12'h0EF, 8'd1, 8'd2, 8'd3, 8'd50, 8'd4, 1, acc2);
            begin
                repeat (6) @(posedge clk);
                force_rdy = 1;
            end
        join
        check("accept_after_handshake", acc2 - hs_cyc, 1);
        drain0();

        // C_T=250 instance: l' overflows 8 bits
        rom1[77] = {8'd10, 24'h123456};
        @(posedge clk);
        #1;
        bus1.position = T_INS; bus1.addr = 12'h777; bus1.i_in = 8'd8; bus1.z_in = 8'd9;
        bus1.k_in = 8'd1; bus1.l_in = 8'd77; bus1.data_1 = 8'd3; bus1.in_valid = 1'b1;
        n = 0;
        while (!bus1.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        e1 = model(T_INS, 12'h777, 8'd8, 8'd9, 8'd1, 8'd77, 8'd3, rom1[77], 1, 5, 9, 250);
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dut1_latency", n, 4);
        check("dut1_k_out", bus1.k_out, e1.k);
        check("dut1_l_out", bus1.l_out, e1.l);
        check("dut1_empty_out", bus1.empty_out, e1.empty);
        check("dut1_addr_out", bus1.addr_out, e1.addr);

        // randomized traffic with random backpressure
        rand_rdy = 1;
        for (int t = 0; t < 150; t++) begin
            kr = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            send0(5'($urandom_range(0, 31)), 12'($urandom), 8'($urandom), 8'($urandom),
                  kr, 8'($urandom), 8'($urandom), 1, acc);
        end
        drain0();
        rand_rdy = 0;
        force_rdy = 1;
        repeat (3) @(posedge clk);

        // reset while in CAPTURE: transaction abandoned
        ign_ce = 1;
        send0(C_INS, 12'h055, 8'd1, 8'd1, 8'd5, 8'd9, 8'd1, 0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ce", bus0.ce_rom_Occ, 0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus0.out_valid) n++;
        end
        check("rst_mid_no_out_valid", n, 0);
        ign_ce = 0;
        check("rst_mid_in_ready", bus0.in_ready, 1);

        // still functional after the abort
        send0(NONE, 12'h066, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 1, acc);
        drain0();
        check("scoreboard_empty", sb0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
